// File: rtl/sdff_bank.sv
// sdff_bank: multi-bit muxed-scan register bank with per-bit async reset value.
// One scan-chain segment per bank. A shift counter reports when WIDTH
// consecutive shifts have completed.
//
// Optional feature macro: SDFF_BANK_SDONE_EN
//   defined   -> shift counter and SDONE pulse logic are built
//   undefined -> no counter; SDONE is tied to 0 (port list unchanged)
//
// Ports:
//   CK     in   clock, rising edge
//   RN     in   asynchronous active-low reset (loads RST_VAL)
//   D      in   [WIDTH] parallel data
//   EN     in   functional load enable
//   SE     in   scan enable (overrides EN)
//   SI     in   scan-in bit
//   Q      out  [WIDTH] register contents
//   QN     out  [WIDTH] ~Q
//   SO     out  chain-end bit of Q
//   SDONE  out  one-cycle pulse after WIDTH consecutive shifts
module sdff_bank #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RST_VAL      = '0,
  parameter bit                SHIFT_MSB_IN = 1'b0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             SDONE
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shift_val;

  // Shift expressed with shift operators so WIDTH=1 reduces cleanly to SI.
  always_comb begin
    shift_val = '0;
    if (SHIFT_MSB_IN) begin
      shift_val = (Q >> 1) | (WIDTH'(SI) << (WIDTH - 1));
    end else begin
      shift_val = (Q << 1) | WIDTH'(SI);
    end
  end

  // Mode select: shift beats load, otherwise hold.
  always_comb begin
    q_nxt = Q;
    if (SE) begin
      q_nxt = shift_val;
    end else if (EN) begin
      q_nxt = D;
    end
  end

  // Data register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      Q <= RST_VAL;
    end else begin
      Q <= q_nxt;
    end
  end

  // Complement and chain end follow the register directly.
  assign QN = ~Q;
  assign SO = SHIFT_MSB_IN ? Q[0] : Q[WIDTH-1];

`ifdef SDFF_BANK_SDONE_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          sdone_nxt;

  // Count consecutive shifts; wrap and pulse on the WIDTH-th one.
  always_comb begin
    cnt_nxt   = '0;
    sdone_nxt = 1'b0;
    if (SE) begin
      if (cnt == CW'(WIDTH - 1)) begin
        sdone_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt   <= '0;
      SDONE <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      SDONE <= sdone_nxt;
    end
  end
`else
  assign SDONE = 1'b0;
`endif

endmodule
